// File: rtl/read_pointer_empty_level.sv
// Read-side pointer logic for an asynchronous FIFO: Gray read pointer, write-pointer
// synchronizer, and registered empty / almost-empty / level / underflow flags.
module read_pointer_empty_level #(
   parameter int ADDRESS_SIZE       = 3,
   parameter int SYNC_STAGES        = 2,
   parameter int ALMOST_EMPTY_LEVEL = 1
) (
   input  logic                    read_clk,
   input  logic                    read_reset,
   input  logic                    read_increment,
   input  logic [ADDRESS_SIZE:0]   write_pointer,
   output logic [ADDRESS_SIZE-1:0] read_address,
   output logic [ADDRESS_SIZE:0]   read_pointer,
   output logic                    read_empty,
   output logic                    read_almost_empty,
   output logic [ADDRESS_SIZE:0]   read_level,
   output logic                    read_underflow
);

   localparam int PW = ADDRESS_SIZE + 1;
   localparam logic [ADDRESS_SIZE:0] AE_LEVEL = PW'(ALMOST_EMPTY_LEVEL);

   function automatic logic [ADDRESS_SIZE:0] bin_to_gray(input logic [ADDRESS_SIZE:0] b);
      return (b >> 1) ^ b;
   endfunction

   function automatic logic [ADDRESS_SIZE:0] gray_to_bin(input logic [ADDRESS_SIZE:0] g);
      logic [ADDRESS_SIZE:0] b;
      b[ADDRESS_SIZE] = g[ADDRESS_SIZE];
      for (int i = ADDRESS_SIZE - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [ADDRESS_SIZE:0] rbin;
   logic [ADDRESS_SIZE:0] rbin_next;
   logic [ADDRESS_SIZE:0] rgraynext;
   logic [ADDRESS_SIZE:0] sync_chain [SYNC_STAGES];
   logic [ADDRESS_SIZE:0] sync_wptr;
   logic [ADDRESS_SIZE:0] wbin_s;
   logic [ADDRESS_SIZE:0] level_next;
   logic                  pop;

   // Only the first synchronizer stage ever samples the foreign-domain pointer.
   always_ff @(posedge read_clk) begin
      if (read_reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_chain[i] <= '0;
         end
      end else begin
         sync_chain[0] <= write_pointer;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_chain[i] <= sync_chain[i-1];
         end
      end
   end

   assign sync_wptr  = sync_chain[SYNC_STAGES-1];
   assign wbin_s     = gray_to_bin(sync_wptr);
   assign pop        = read_increment & ~read_empty;
   assign rbin_next  = rbin + {{ADDRESS_SIZE{1'b0}}, pop};
   assign rgraynext  = bin_to_gray(rbin_next);
   // Flags are computed from the post-pop pointer so an emptying read flags empty at once.
   assign level_next = wbin_s - rbin_next;

   always_ff @(posedge read_clk) begin
      if (read_reset) begin
         rbin              <= '0;
         read_address      <= '0;
         read_pointer      <= '0;
         read_level        <= '0;
         read_empty        <= 1'b1;
         read_almost_empty <= 1'b1;
         read_underflow    <= 1'b0;
      end else begin
         rbin              <= rbin_next;
         read_address      <= rbin_next[ADDRESS_SIZE-1:0];
         read_pointer      <= rgraynext;
         read_level        <= level_next;
         read_empty        <= (rgraynext == sync_wptr);
         read_almost_empty <= (level_next <= AE_LEVEL);
         read_underflow    <= read_increment & read_empty;
      end
   end

endmodule
